// File: rtl/vga_rect_fill_ctrl_if.sv
// ============================================================================
// Module  : vga_rect_fill_ctrl_if
// Brief   : Command and single-pixel request channels of the rectangle filler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_rect_fill_ctrl_if #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 1
);
  // Rectangle command channel
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [COORD_W-1:0] cmd_x0_i;
  logic [COORD_W-1:0] cmd_y0_i;
  logic [COORD_W-1:0] cmd_x1_i;
  logic [COORD_W-1:0] cmd_y1_i;
  logic [COLOR_W-1:0] cmd_color_i;
  logic               abort_i;

  // Single-pixel request channel
  logic               pix_valid_i;
  logic               pix_ready_o;
  logic [COORD_W-1:0] pix_x_i;
  logic [COORD_W-1:0] pix_y_i;
  logic [COLOR_W-1:0] pix_color_i;

  modport master (
    output cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
    output abort_i,
    output pix_valid_i, pix_x_i, pix_y_i, pix_color_i,
    input  cmd_ready_o, pix_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
    input  abort_i,
    input  pix_valid_i, pix_x_i, pix_y_i, pix_color_i,
    output cmd_ready_o, pix_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/vga_rect_fill_ctrl.sv
// ============================================================================
// Module  : vga_rect_fill_ctrl
// Brief   : Clipped rectangle-fill sequencer sharing the VGA pixel write port
//           with a single-pixel request path (alternating arbitration).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rect_fill_ctrl #(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = 20
) (
  input  wire logic               clk_i,
  input  wire logic               rstn_i,
  vga_rect_fill_ctrl_if.slave     bus,
  output logic [COORD_W-1:0]      vga_addr_x_o,
  output logic [COORD_W-1:0]      vga_addr_y_o,
  output logic [COLOR_W-1:0]      vga_color_o,
  output logic                    vga_we_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_W-1:0]        pix_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [COORD_W-1:0] c_scr_w = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] c_scr_h = COORD_W'(SCREEN_H);
  localparam logic [COORD_W-1:0] c_x_max = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] c_y_max = COORD_W'(SCREEN_H - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_last_fill;
  logic [COORD_W-1:0] r_xa, r_xb, r_yb;
  logic [COORD_W-1:0] r_cx, r_cy;
  logic [COLOR_W-1:0] r_color;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [COORD_W-1:0] r_addr_x, r_addr_y;
  logic [COLOR_W-1:0] r_out_color;
  logic               r_we;
  logic               r_done;

  logic               w_accept;
  logic               w_grant_pix;
  logic               w_grant_fill;
  logic               w_pix_ready;
  logic               w_row_end;
  logic               w_last_pix;
  logic               w_empty;
  logic [COORD_W-1:0] w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [COORD_W-1:0] w_xb_clip, w_yb_clip;

  // Corner normalisation and clipping of the incoming command
  always_comb begin
    w_x_lo    = (bus.cmd_x0_i < bus.cmd_x1_i) ? bus.cmd_x0_i : bus.cmd_x1_i;
    w_x_hi    = (bus.cmd_x0_i < bus.cmd_x1_i) ? bus.cmd_x1_i : bus.cmd_x0_i;
    w_y_lo    = (bus.cmd_y0_i < bus.cmd_y1_i) ? bus.cmd_y0_i : bus.cmd_y1_i;
    w_y_hi    = (bus.cmd_y0_i < bus.cmd_y1_i) ? bus.cmd_y1_i : bus.cmd_y0_i;
    w_xb_clip = (w_x_hi > c_x_max) ? c_x_max : w_x_hi;
    w_yb_clip = (w_y_hi > c_y_max) ? c_y_max : w_y_hi;
    w_empty   = (w_x_lo >= c_scr_w) || (w_y_lo >= c_scr_h);
  end

  // Pixel path wins unless the fill was passed over on the previous grant,
  // so under contention the two requesters alternate.
  assign w_accept     = (r_state == S_IDLE) && bus.cmd_valid_i;
  assign w_pix_ready  = (r_state != S_FILL) || r_last_fill;
  assign w_grant_pix  = bus.pix_valid_i && w_pix_ready;
  assign w_grant_fill = (r_state == S_FILL) && !w_grant_pix && !bus.abort_i;
  assign w_row_end    = (r_cx == r_xb);
  assign w_last_pix   = w_row_end && (r_cy == r_yb);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          w_state_nxt = w_empty ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.abort_i || (w_grant_fill && w_last_pix)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_last_fill <= 1'b0;
      r_xa        <= '0;
      r_xb        <= '0;
      r_yb        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_color     <= '0;
      r_pix_cnt   <= '0;
      r_addr_x    <= '0;
      r_addr_y    <= '0;
      r_out_color <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_grant_pix || w_grant_fill;
      r_done  <= (w_state_nxt == S_DONE);

      if (w_grant_pix) begin
        r_last_fill <= 1'b0;
      end else if (w_grant_fill) begin
        r_last_fill <= 1'b1;
      end

      if (w_accept) begin
        r_xa      <= w_x_lo;
        r_xb      <= w_xb_clip;
        r_yb      <= w_yb_clip;
        r_cx      <= w_x_lo;
        r_cy      <= w_y_lo;
        r_color   <= bus.cmd_color_i;
        r_pix_cnt <= '0;
      end

      if (w_grant_pix) begin
        r_addr_x    <= bus.pix_x_i;
        r_addr_y    <= bus.pix_y_i;
        r_out_color <= bus.pix_color_i;
      end else if (w_grant_fill) begin
        r_addr_x    <= r_cx;
        r_addr_y    <= r_cy;
        r_out_color <= r_color;
        r_pix_cnt   <= r_pix_cnt + CNT_W'(1);
        // Raster order: x inner, y outer
        if (w_row_end) begin
          r_cx <= r_xa;
          if (!w_last_pix) begin
            r_cy <= r_cy + COORD_W'(1);
          end
        end else begin
          r_cx <= r_cx + COORD_W'(1);
        end
      end
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE);
  assign bus.pix_ready_o = w_pix_ready;
  assign vga_addr_x_o    = r_addr_x;
  assign vga_addr_y_o    = r_addr_y;
  assign vga_color_o     = r_out_color;
  assign vga_we_o        = r_we;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign pix_count_o     = r_pix_cnt;

endmodule

`default_nettype wire

// File: doc/vga_rect_fill_ctrl.md
Name: vga_rect_fill_ctrl

Overview:
Rectangle-fill sequencer for the VGA pixel write port (addr_x / addr_y / color / we) of the VGA frame memory. It accepts a rectangle command over a valid/ready handshake, normalises and clips it to the screen, and raster-sweeps one pixel write per cycle. It also arbitrates the same write port with a single-pixel request path (the APB register path), so software pixel writes and hardware fills share the frame memory.

Parameters:
COORD_W, 11, coordinate width of x/y (matches frame memory address width)
SCREEN_W, 640, visible width in pixels; valid x is 0..SCREEN_W-1
SCREEN_H, 480, visible height in pixels; valid y is 0..SCREEN_H-1
COLOR_W, 1, pixel colour width
CNT_W, 20, width of the fill pixel counter

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  rectangle command valid
cmd_ready_o  out  1  command accepted when valid & ready
cmd_x0_i / cmd_y0_i  in  COORD_W  first corner
cmd_x1_i / cmd_y1_i  in  COORD_W  opposite corner (any order)
cmd_color_i  in  COLOR_W  fill colour
abort_i  in  1  abort active fill
pix_valid_i  in  1  single-pixel write request
pix_ready_o  out  1  single-pixel grant (combinational)
pix_x_i / pix_y_i  in  COORD_W  single-pixel coordinates
pix_color_i  in  COLOR_W  single-pixel colour
vga_addr_x_o / vga_addr_y_o  out  COORD_W  to frame memory addr_x / addr_y
vga_color_o  out  COLOR_W  to frame memory color
vga_we_o  out  1  one-cycle write strobe per pixel
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at fill completion or abort
pix_count_o  out  CNT_W  fill writes issued for the current/last command

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low on rstn_i. Every flop clears on reset: state=IDLE, vga_we_o=0, vga_addr_x_o=0, vga_addr_y_o=0, vga_color_o=0, done_o=0, pix_count_o=0, last_fill=0. While reset is held and after release, cmd_ready_o=1 and busy_o=0.
- FSM states: IDLE, FILL, DONE.
- cmd_ready_o = (state==IDLE).
- On accept (IDLE, cmd_valid_i=1):
  - Latch xa=min(x0,x1), xb=min(max(x0,x1), SCREEN_W-1), ya=min(y0,y1), yb=min(max(y0,y1), SCREEN_H-1), and colour.
  - Set cx=xa, cy=ya, pix_count=0.
  - If xa>=SCREEN_W or ya>=SCREEN_H, the rectangle is empty: go to DONE with no writes. Otherwise go to FILL.
- Arbitration:
  - pix_ready_o = (state!=FILL) | last_fill.
  - grant_pix = pix_valid_i & pix_ready_o.
  - grant_fill = (state==FILL) & ~grant_pix & ~abort_i.
  - last_fill is set on every grant_fill and cleared on every grant_pix. Under contention, pixel and fill writes alternate; neither path can starve.
- Write port:
  - Outputs are registered. A grant at edge E loads addr/color and sets vga_we_o=1 for the cycle after E.
  - vga_we_o=0 in any cycle with no grant at the preceding edge; addr and colour hold their last values.
  - A single-pixel write is issued as given (no clipping), in any state.
- Fill sweep, on each grant_fill writing (cx,cy):
  - pix_count+1.
  - If cx==xb then cx=xa and, if cy==yb, this is the last pixel: state=DONE; else cy+1.
  - Otherwise cx+1.
  - Order is raster: x inner, y outer.
- DONE lasts one cycle: done_o=1 in that cycle, then state=IDLE. First write appears the cycle after FILL is entered. done_o asserts the same cycle the last fill write is on vga_we_o.
- Abort: abort_i=1 in FILL at edge E means no fill write is granted at E and state=DONE. pix_count keeps the number of writes already issued. A pixel grant at E is still honoured. abort_i is ignored in IDLE and DONE.
- cmd_valid_i is ignored while busy. No command queueing.
- An async reset mid-FILL drops vga_we_o to 0 immediately. No partial fill resumes.

Test Plan:
1. Cmd (2,3)-(4,4), colour 1, no pixel traffic -> six vga_we_o pulses on consecutive cycles: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). done_o coincides with the last pulse; pix_count_o=6; cmd_ready_o=1 the next cycle.
2. Swapped corners, cmd (4,4)-(2,3) -> identical sequence to scenario 1.
3. Clipping:
   - Cmd (638,479)-(700,500) -> exactly two writes, (638,479) and (639,479).
   - Cmd (640,0)-(650,5) -> zero writes, done_o pulse one cycle after accept, pix_count_o=0.
4. Cmd (0,0)-(3,0) with pix_valid_i held high, pixel (100,200) colour 0 -> eight consecutive write cycles alternating fill/pixel. Fill writes are (0,0),(1,0),(2,0),(3,0) in order. pix_ready_o toggles each cycle; pix_count_o=4.
5. Cmd (0,0)-(9,9), abort_i pulsed at the edge after the 3rd fill write is granted -> no further fill writes, done_o one-cycle pulse, pix_count_o=3, next command accepted normally.
6. rstn_i driven low mid-fill of (0,0)-(9,9) -> vga_we_o, busy_o and done_o are 0 immediately. After release: cmd_ready_o=1, no writes until a new command, pix_count_o=0.
